move_sequencer: RTL and testbench

- Sequences one 2048 move across the 4x4 board by time-sharing a single line-merge unit among the four rows or columns.
- Per accepted move request: latches the board, issues each of 4 lines in slide order, collects merged results, writes the updated board back, and requests a tile spawn only if the board changed.
- Sits between the top-level game FSM (move_req / done) and the shared line-merge and tile-spawn units.

---
 rtl/move_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_move_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
`timescale 1ns/1ps
// Runs one 2048 move by feeding the four rows/columns through a shared line-merge unit, writing back the board and requesting a spawn.
// Latency: 1 accept + 2 cycles per line + COMMIT + DONE (+ spawn). Backpressure: holds each line until line_ready; any handshake stalled TIMEOUT cycles aborts.
module move_sequencer #(
    parameter int TIMEOUT  = 255,
    parameter bit SPAWN_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        move_req,
    input  logic [3:0]  direction,
    input  logic        game_over,
    input  logic [63:0] board_in,
    output logic        line_valid,
    input  logic        line_ready,
    output logic [15:0] line_data,
    input  logic        result_valid,
    input  logic [15:0] result_data,
    output logic [63:0] board_out,
    output logic        board_we,
    output logic        spawn_req,
    input  logic        spawn_ack,
    output logic        busy,
    output logic        done,
    output logic        moved,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMMIT,
        S_SPAWN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   orig_q, work_q, work_d, board_out_q;
    logic [3:0]    dir_q;
    logic [1:0]    idx_q;
    logic          moved_q, error_q;
    logic [TW-1:0] tmo_q;
    logic          accept, tmo_hit, abort, res_take;
    logic [15:0]   issued;

    // Box number (0 = top-left, row-major) holding tile t of line i; tile 0 leads in the slide direction.
    function automatic logic [3:0] box_of(input logic [3:0] dir, input logic [1:0] line, input logic [1:0] tile);
        logic [3:0] k;
        if (dir[3])
            k = {tile, line};
        else if (dir[2])
            k = {~tile, line};
        else if (dir[0])
            k = {line, ~tile};
        else
            k = {line, tile};
        return k;
    endfunction

    assign accept   = (state_q == S_IDLE) && move_req && !game_over && $onehot(direction);
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign res_take = (state_q == S_WAIT) && result_valid;

    always_comb begin
        issued = '0;
        for (int t = 0; t < 4; t++) begin
            issued[15-4*t -: 4] = orig_q[63-4*int'(box_of(dir_q, idx_q, 2'(t))) -: 4];
        end
    end

    always_comb begin
        work_d = work_q;
        if (accept) begin
            work_d = board_in;
        end else if (res_take) begin
            for (int t = 0; t < 4; t++) begin
                work_d[63-4*int'(box_of(dir_q, idx_q, 2'(t))) -: 4] = result_data[15-4*t -: 4];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a completed handshake wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (line_ready) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end
            end
            S_WAIT: begin
                if (result_valid) begin
                    state_d = (idx_q == 2'd3) ? S_COMMIT : S_ISSUE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = (moved_q && SPAWN_EN) ? S_SPAWN : S_DONE;
            end
            S_SPAWN: begin
                if (spawn_ack) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            orig_q      <= '0;
            work_q      <= '0;
            board_out_q <= '0;
            dir_q       <= '0;
            idx_q       <= '0;
            moved_q     <= 1'b0;
            error_q     <= 1'b0;
            tmo_q       <= '0;
        end else begin
            work_q <= work_d;
            if (state_d != state_q)
                tmo_q <= '0;
            else if (state_q inside {S_ISSUE, S_WAIT, S_SPAWN})
                tmo_q <= tmo_q + 1'b1;
            if (accept) begin
                orig_q  <= board_in;
                dir_q   <= direction;
                idx_q   <= '0;
                moved_q <= 1'b0;
                error_q <= 1'b0;
            end
            if (res_take) begin
                idx_q <= idx_q + 1'b1;
                if (result_data != issued)
                    moved_q <= 1'b1;
            end
            // A spawn-stage abort keeps moved: the board has already been written.
            if (abort) begin
                error_q <= 1'b1;
                if (state_q != S_SPAWN)
                    moved_q <= 1'b0;
            end
            if (state_q == S_COMMIT && moved_q)
                board_out_q <= work_q;
        end
    end

    // Outputs; board_out shows the new board in the same cycle as its write strobe.
    always_comb begin
        busy       = (state_q != S_IDLE);
        line_valid = (state_q == S_ISSUE);
        line_data  = issued;
        spawn_req  = (state_q == S_SPAWN);
        done       = (state_q == S_DONE);
        board_we   = (state_q == S_COMMIT) && moved_q;
        board_out  = board_we ? work_q : board_out_q;
        moved      = moved_q;
        error      = error_q;
    end

endmodule

// File: tb/tb_move_sequencer.sv
`timescale 1ns/1ps
// Directed bench for move_sequencer: models the merge and spawn units and checks line order, write-back, filtering, timeout and reset.
module tb_move_sequencer;

    localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010, RIGHT = 4'b0001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        move_req = 1'b0, t_move_req = 1'b0;
    logic [3:0]  direction = 4'b0000;
    logic        game_over = 1'b0;
    logic [63:0] board_in = '0;
    logic        line_ready = 1'b1;
    logic        result_valid = 1'b0;
    logic [15:0] result_data = '0;
    logic        spawn_ack = 1'b0;
    logic        t_zero;
    logic [15:0] t_zero16;

    logic        line_valid, board_we, spawn_req, busy, done, moved, error;
    logic [15:0] line_data;
    logic [63:0] board_out;
    logic        t_line_valid, t_board_we, t_spawn_req, t_busy, t_done, t_moved, t_error;
    logic [15:0] t_line_data;
    logic [63:0] t_board_out;

    assign t_zero   = 1'b0;
    assign t_zero16 = 16'h0000;

    move_sequencer dut (
        .clock(clock), .reset(reset), .move_req(move_req), .direction(direction),
        .game_over(game_over), .board_in(board_in), .line_valid(line_valid),
        .line_ready(line_ready), .line_data(line_data), .result_valid(result_valid),
        .result_data(result_data), .board_out(board_out), .board_we(board_we),
        .spawn_req(spawn_req), .spawn_ack(spawn_ack), .busy(busy), .done(done),
        .moved(moved), .error(error)
    );

    move_sequencer #(.TIMEOUT(8)) dut_t (
        .clock(clock), .reset(reset), .move_req(t_move_req), .direction(direction),
        .game_over(game_over), .board_in(board_in), .line_valid(t_line_valid),
        .line_ready(t_zero), .line_data(t_line_data), .result_valid(t_zero),
        .result_data(t_zero16), .board_out(t_board_out), .board_we(t_board_we),
        .spawn_req(t_spawn_req), .spawn_ack(t_zero), .busy(t_busy), .done(t_done),
        .moved(t_moved), .error(t_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;
    int tot_lines = 0, tot_we = 0, tot_spawn = 0, tot_busy = 0, tot_done = 0, sp_run = 0;
    int b_lines = 0, b_we = 0, b_spawn = 0, b_busy = 0, b_done = 0;
    int t_tot_valid = 0, t_tot_we = 0, t_tot_done = 0, t_tot_spawn = 0;
    logic [15:0] lines [256];
    logic [15:0] pend_dat = '0, t_first = '0;
    logic        pend = 1'b0;
    logic        use_line0 = 1'b0;
    logic [15:0] line0_res = '0;
    logic [63:0] we_board = '0;
    logic        last_moved = 1'b0, last_error = 1'b0, t_last_moved = 1'b0, t_last_error = 1'b0;

    // Merge unit (result one cycle after transfer), spawn unit (ack in 3rd request cycle) and event monitor.
    always @(negedge clock) begin
        result_valid = 1'b0;
        if (pend) begin
            result_valid = 1'b1;
            result_data  = pend_dat;
            pend         = 1'b0;
        end
        if (line_valid && line_ready) begin
            lines[tot_lines & 255] = line_data;
            pend_dat = (use_line0 && tot_lines == b_lines) ? line0_res : line_data;
            pend = 1'b1;
            tot_lines++;
        end
        if (spawn_req) begin
            sp_run++;
            spawn_ack = (sp_run == 3);
            tot_spawn++;
        end else begin
            sp_run    = 0;
            spawn_ack = 1'b0;
        end
        if (board_we) begin
            tot_we++;
            we_board = board_out;
        end
        if (busy) tot_busy++;
        if (done) begin
            tot_done++;
            last_moved = moved;
            last_error = error;
        end
        if (t_line_valid) begin
            if (t_tot_valid == 0) t_first = t_line_data;
            t_tot_valid++;
        end
        if (t_board_we) t_tot_we++;
        if (t_spawn_req) t_tot_spawn++;
        if (t_done) begin
            t_tot_done++;
            t_last_moved = t_moved;
            t_last_error = t_error;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulse(input logic [3:0] dir, input logic [63:0] brd);
        b_lines = tot_lines; b_we = tot_we; b_spawn = tot_spawn; b_busy = tot_busy; b_done = tot_done;
        direction = dir;
        board_in  = brd;
        move_req  = 1'b1;
        step(1);
        move_req  = 1'b0;
        direction = RIGHT;
        board_in  = ~brd;
    endtask

    task automatic wait_done(input int extra_at);
        int c = 0;
        while (tot_done == b_done && c < 200) begin
            move_req = (c == extra_at);
            step(1);
            c++;
        end
        move_req = 1'b0;
        chk("done_within_bound", 64'(tot_done != b_done), 64'd1);
        step(2);
    endtask

    initial begin
        step(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_line_valid", 64'(line_valid), 64'd0);
        chk("rst_board_we", 64'(board_we), 64'd0);
        chk("rst_spawn_req", 64'(spawn_req), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_moved", 64'(moved), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_board_out", board_out, 64'd0);
        reset = 1'b0;
        step(1);

        // Left move that merges row 0 and spawns
        use_line0 = 1'b1; line0_res = 16'h2000;
        pulse(LEFT, 64'h1100_0000_0000_0000);
        wait_done(-1);
        chk("left_nlines", 64'(tot_lines - b_lines), 64'd4);
        chk("left_line0", 64'(lines[b_lines & 255]), 64'h1100);
        chk("left_we_count", 64'(tot_we - b_we), 64'd1);
        chk("left_we_board", we_board, 64'h2000_0000_0000_0000);
        chk("left_spawn_cycles", 64'(tot_spawn - b_spawn), 64'd3);
        chk("left_busy_cycles", 64'(tot_busy - b_busy), 64'd13);
        chk("left_moved", 64'(last_moved), 64'd1);
        chk("left_error", 64'(last_error), 64'd0);
        chk("left_board_out", board_out, 64'h2000_0000_0000_0000);

        // No-change left move with distinct rows: row order and no write/spawn
        use_line0 = 1'b0;
        pulse(LEFT, 64'h1100_2000_0300_0004);
        wait_done(-1);
        chk("nochg_line1", 64'(lines[(b_lines + 1) & 255]), 64'h2000);
        chk("nochg_line2", 64'(lines[(b_lines + 2) & 255]), 64'h0300);
        chk("nochg_line3", 64'(lines[(b_lines + 3) & 255]), 64'h0004);
        chk("nochg_we_count", 64'(tot_we - b_we), 64'd0);
        chk("nochg_spawn", 64'(tot_spawn - b_spawn), 64'd0);
        chk("nochg_busy_cycles", 64'(tot_busy - b_busy), 64'd10);
        chk("nochg_moved", 64'(last_moved), 64'd0);
        chk("nochg_board_out_held", board_out, 64'h2000_0000_0000_0000);

        // Up: column order and column write-back
        use_line0 = 1'b1; line0_res = 16'h5000;
        pulse(UP, 64'h1000_2000_3000_4000);
        wait_done(-1);
        chk("up_line0", 64'(lines[b_lines & 255]), 64'h1234);
        chk("up_line1", 64'(lines[(b_lines + 1) & 255]), 64'h0000);
        chk("up_we_board", we_board, 64'h5000_0000_0000_0000);

        line0_res = 16'h6000;
        pulse(DOWN, 64'h1000_2000_3000_4000);
        wait_done(-1);
        chk("down_line0", 64'(lines[b_lines & 255]), 64'h4321);
        chk("down_we_board", we_board, 64'h0000_0000_0000_6000);

        line0_res = 16'h7000;
        pulse(RIGHT, 64'h1234_0000_0000_0000);
        wait_done(-1);
        chk("right_line0", 64'(lines[b_lines & 255]), 64'h4321);
        chk("right_we_board", we_board, 64'h0007_0000_0000_0000);
        chk("right_moved", 64'(last_moved), 64'd1);

        // move_req while busy is dropped
        use_line0 = 1'b0;
        pulse(LEFT, 64'h1100_2000_0300_0004);
        wait_done(3);
        step(10);
        chk("midreq_done_count", 64'(tot_done - b_done), 64'd1);
        chk("midreq_busy_cycles", 64'(tot_busy - b_busy), 64'd10);

        // Request filtering
        pulse(4'b0110, 64'h1100_0000_0000_0000);
        step(4);
        chk("twohot_no_busy", 64'(tot_busy - b_busy), 64'd0);
        game_over = 1'b1;
        pulse(LEFT, 64'h1100_0000_0000_0000);
        step(4);
        chk("gameover_no_busy", 64'(tot_busy - b_busy), 64'd0);
        game_over = 1'b0;

        // Timeout on the TIMEOUT=8 instance with line_ready stuck low
        direction = LEFT; board_in = 64'hABCD_0000_0000_0000;
        t_move_req = 1'b1;
        step(1);
        t_move_req = 1'b0;
        board_in = '0;
        for (int c = 0; c < 40 && t_tot_done == 0; c++) step(1);
        step(2);
        chk("tmo_done_count", 64'(t_tot_done), 64'd1);
        chk("tmo_valid_cycles", 64'(t_tot_valid), 64'd8);
        chk("tmo_first_line", 64'(t_first), 64'hABCD);
        chk("tmo_we_count", 64'(t_tot_we), 64'd0);
        chk("tmo_spawn", 64'(t_tot_spawn), 64'd0);
        chk("tmo_error", 64'(t_last_error), 64'd1);
        chk("tmo_moved", 64'(t_last_moved), 64'd0);
        chk("tmo_idle", 64'(t_busy), 64'd0);
        chk("tmo_board_out", t_board_out, 64'd0);

        // Reset during WAIT_RES of line 2
        use_line0 = 1'b1; line0_res = 16'h2000;
        pulse(LEFT, 64'h1100_0000_0000_0000);
        for (int c = 0; c < 50 && (tot_lines - b_lines) < 3; c++) step(1);
        chk("rstmid_reached_line2", 64'(tot_lines - b_lines), 64'd3);
        reset = 1'b1;
        step(1);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_line_valid", 64'(line_valid), 64'd0);
        chk("rstmid_board_out", board_out, 64'd0);
        reset = 1'b0;
        step(5);
        chk("rstmid_no_done", 64'(tot_done - b_done), 64'd0);
        chk("rstmid_no_we", 64'(tot_we - b_we), 64'd0);

        pulse(LEFT, 64'h1100_0000_0000_0000);
        wait_done(-1);
        chk("after_rst_we_board", we_board, 64'h2000_0000_0000_0000);
        chk("after_rst_moved", 64'(last_moved), 64'd1);
        chk("after_rst_error", 64'(last_error), 64'd0);
        chk("after_rst_board_out", board_out, 64'h2000_0000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
